// File: rtl/stage4_mem.sv
// stage4_mem: MEM stage of the 5-stage RV64 pipeline.
// Holds the EX/MEM register, a doubleword-indexed data memory with a
// configurable access latency, branch resolution and the MEM/WB register.
// A multi-cycle load/store freezes EX/MEM and raises stall to upstream stages.
// Optional feature: define MEM_MISALIGN_CHECK_EN to suppress accesses whose
// byte address is not doubleword aligned and report them on misalign.
module stage4_mem #(
  parameter int XLEN        = 64,
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [XLEN-1:0] sum,
  input  logic            zero,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] read_data2,
  input  logic [4:0]      write_register,
  input  logic            MemToReg_in,
  input  logic            RegWrite_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  input  logic            Branch_in,
  output logic            stall,
  output logic            pc_src,
  output logic [XLEN-1:0] branch_target,
  output logic            valid_out,
  output logic [XLEN-1:0] read_data_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [4:0]      write_register_out,
  output logic            MemToReg_out,
  output logic            RegWrite_out,
  output logic            misalign
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAT   = 4'(MEM_LATENCY);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] cnt;

  // EX/MEM pipeline register
  logic            valid_q;
  logic            zero_q;
  logic            memtoreg_q;
  logic            regwrite_q;
  logic            memread_q;
  logic            memwrite_q;
  logic            branch_q;
  logic [XLEN-1:0] sum_q;
  logic [XLEN-1:0] alu_result_q;
  logic [XLEN-1:0] read_data2_q;
  logic [4:0]      write_register_q;

  // Data memory, one XLEN-wide word per index
  logic [XLEN-1:0] mem [DEPTH];

  logic              access;
  logic              is_load;
  logic              is_store;
  logic              mis_acc;
  logic              start_busy;
  logic              advance;
  logic [ADDR_W-1:0] index;

  // A load with MemWrite also set is treated as a store, so it returns no data.
  assign access   = valid_q & (memread_q | memwrite_q);
  assign is_store = memwrite_q;
  assign is_load  = memread_q & ~memwrite_q;
  // Byte address to doubleword index; address bits above the array wrap.
  assign index    = alu_result_q[ADDR_W+2:3];

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis_acc = access & (alu_result_q[2:0] != 3'b000);
`else
  assign mis_acc = 1'b0;
`endif

  // Branch resolution straight from the EX/MEM register; branches never stall.
  assign pc_src        = valid_q & branch_q & zero_q;
  assign branch_target = sum_q;

  // Access sequencing: decide whether this cycle stalls, starts a wait, or completes.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would make synthesis infer a latch.
  always_comb begin
    stall      = 1'b0;
    start_busy = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (access && (LAT != 4'd0)) begin
          start_busy = 1'b1;
          stall      = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          advance = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // EX/MEM capture; held while stalled, and a flush only lands when not stalled.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q          <= 1'b0;
      zero_q           <= 1'b0;
      memtoreg_q       <= 1'b0;
      regwrite_q       <= 1'b0;
      memread_q        <= 1'b0;
      memwrite_q       <= 1'b0;
      branch_q         <= 1'b0;
      sum_q            <= '0;
      alu_result_q     <= '0;
      read_data2_q     <= '0;
      write_register_q <= '0;
    end else if (!stall) begin
      valid_q          <= valid_in & ~flush;
      zero_q           <= zero;
      memtoreg_q       <= MemToReg_in;
      regwrite_q       <= RegWrite_in;
      memread_q        <= MemRead_in;
      memwrite_q       <= MemWrite_in;
      branch_q         <= Branch_in;
      sum_q            <= sum;
      alu_result_q     <= alu_result;
      read_data2_q     <= read_data2;
      write_register_q <= write_register;
    end
  end

  // Latency FSM: count down MEM_LATENCY wait cycles, final count completes the access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_busy) begin
            state <= BUSY;
            cnt   <= LAT;
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // MEM/WB register: pass the completed instruction on, or insert a bubble while waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out          <= 1'b0;
      read_data_out      <= '0;
      alu_result_out     <= '0;
      write_register_out <= '0;
      MemToReg_out       <= 1'b0;
      RegWrite_out       <= 1'b0;
    end else if (advance) begin
      valid_out          <= valid_q;
      alu_result_out     <= alu_result_q;
      write_register_out <= write_register_q;
      MemToReg_out       <= memtoreg_q;
      RegWrite_out       <= regwrite_q & valid_q & ~mis_acc;
      if (access && is_load && !mis_acc) begin
        read_data_out <= mem[index];
      end else begin
        read_data_out <= '0;
      end
    end else begin
      valid_out          <= 1'b0;
      read_data_out      <= '0;
      alu_result_out     <= '0;
      write_register_out <= '0;
      MemToReg_out       <= 1'b0;
      RegWrite_out       <= 1'b0;
    end
  end

  // Store commit on the completing edge; a reset on that edge drops the store.
  // NOTE: the memory array has no reset branch; clearing it would turn the
  // RAM into a large bank of flops, and software never relies on its contents.
  always_ff @(posedge clk) begin
    if (rst_n && advance && access && is_store && !mis_acc) begin
      mem[index] <= read_data2_q;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Misalign flag travels with the completing access for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else begin
      misalign <= advance & mis_acc;
    end
  end
`else
  assign misalign = 1'b0;
`endif

endmodule
